// File: rtl/ttrng_pkg.sv
// ttrng_pkg: state encoding, latch drive constants and counter sizing for the ttrng sequencer
package ttrng_pkg;
  typedef enum logic [2:0] {IDLE, INIT, EXCITE, SETTLE, SAMPLE, WAIT} state_t;
  localparam logic [1:0] LATCH_HOLD = 2'b01;
  localparam logic [1:0] LATCH_EXCITE = 2'b11;
  localparam logic [1:0] LATCH_RELEASE = 2'b00;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/ttrng_vn_packer.sv
// ttrng_vn_packer: von Neumann debias, byte packing and one-deep valid/ready output register
module ttrng_vn_packer (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_valid,
  input  logic       bit_in,
  input  logic       flush,
  input  logic       clear,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       stall,
  output logic       free
);
  logic pair, first, emit, fill, full, load;
  logic [7:0] acc, acc_n;
  logic [3:0] cnt;
  always_comb begin
    free = !out_valid || out_ready;
    emit = bit_valid && pair && (first != bit_in);
    acc_n = {acc[6:0], first};
    fill = emit && cnt == 4'd7;
    full = cnt == 4'd8;
    stall = fill && !free;
    load = (fill || full) && free;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pair <= 1'b0;
      first <= 1'b0;
      acc <= '0;
      cnt <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_ready) out_valid <= 1'b0;
      if (load) begin
        out_data <= full ? acc : acc_n;
        out_valid <= 1'b1;
      end
      if (clear || flush) pair <= 1'b0;
      else if (bit_valid) pair <= !pair;
      if (bit_valid) first <= bit_in;
      // a full accumulator (cnt==8) is parked until the output register frees up
      if (clear) begin
        acc <= '0;
        cnt <= '0;
      end else if (load) cnt <= '0;
      else if (emit) begin
        acc <= acc_n;
        cnt <= cnt + 4'd1;
      end
    end
  end
endmodule

// File: rtl/ttrng_sample_ctrl.sv
// ttrng_sample_ctrl: sequences the SR-latch entropy cell and emits debiased, health-checked bytes
module ttrng_sample_ctrl
  import ttrng_pkg::*;
#(
  parameter int INIT_CYCLES   = 4,
  parameter int EXCITE_CYCLES = 2,
  parameter int SETTLE_CYCLES = 8,
  parameter int REP_LIMIT     = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       raw_bit,
  output logic       latch_s,
  output logic       latch_r,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       health_fail,
  input  logic       health_clr,
  output logic       busy
);
  localparam int PW = cnt_w(INIT_CYCLES + EXCITE_CYCLES + SETTLE_CYCLES);
  localparam int RW = cnt_w(REP_LIMIT);
  state_t state, state_n;
  logic [PW-1:0] phase;
  logic [RW-1:0] rep_cnt, rep_n;
  logic [1:0] raw_sync, drive_n;
  logic last_bit, sample, fail_now, flush, lat, stall, free;
  always_comb begin
    sample = state == SAMPLE;
    rep_n = (rep_cnt != '0 && raw_sync[1] == last_bit) ?
            (rep_cnt == RW'(REP_LIMIT) ? rep_cnt : rep_cnt + RW'(1)) : RW'(1);
    fail_now = sample && rep_n == RW'(REP_LIMIT);
    lat = int'(phase) == (state == INIT ? INIT_CYCLES : state == EXCITE ? EXCITE_CYCLES : SETTLE_CYCLES) - 1;
    state_n = state;
    case (state)
      IDLE:    if (en && !health_fail) state_n = INIT;
      INIT:    if (lat) state_n = EXCITE;
      EXCITE:  if (lat) state_n = SETTLE;
      SETTLE:  if (lat) state_n = SAMPLE;
      SAMPLE:  state_n = fail_now ? IDLE : stall ? WAIT : en ? INIT : IDLE;
      WAIT:    if (free) state_n = en ? INIT : IDLE;
      default: state_n = IDLE;
    endcase
    flush = state != IDLE && state_n == IDLE;
    drive_n = state_n == EXCITE ? LATCH_EXCITE :
              (state_n == SETTLE || state_n == SAMPLE) ? LATCH_RELEASE : LATCH_HOLD;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      phase <= '0;
      raw_sync <= '0;
      last_bit <= 1'b0;
      rep_cnt <= '0;
      health_fail <= 1'b0;
      {latch_s, latch_r} <= LATCH_HOLD;
    end else begin
      state <= state_n;
      phase <= state_n != state ? '0 : phase + 1'b1;
      raw_sync <= {raw_sync[0], raw_bit};
      {latch_s, latch_r} <= drive_n;
      // a failure detected in the clearing cycle still latches
      health_fail <= fail_now || (health_fail && !health_clr);
      rep_cnt <= (health_clr && !fail_now) ? '0 : sample ? rep_n : rep_cnt;
      if (sample) last_bit <= raw_sync[1];
    end
  end
  assign busy = state != IDLE;
  ttrng_vn_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .bit_valid (sample),
    .bit_in    (raw_sync[1]),
    .flush     (flush),
    .clear     (fail_now),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .stall     (stall),
    .free      (free)
  );
endmodule
